// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared types and constants for the move input conditioner
package input_cond_pkg;
  localparam int N_SEL_LINES = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int MOVE_COUNT_W = 8;
  typedef enum logic [0:0] {IDLE, WAIT_RELEASE} fire_state_e;
  function automatic logic [2:0] popcount4(input logic [N_SEL_LINES-1:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: input synchronizer plus consecutive-difference debounce counter
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d, diff, flip;
  always_comb begin
    diff = sync_q[SYNC_STAGES-1] ^ stable_q;
    flip = diff && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d = (diff && !flip) ? cnt_q + 1'b1 : '0;
    stable_d = stable_q ^ flip;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q <= '0;
      cnt_q <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q <= cnt_d;
      stable_q <= stable_d;
    end
  assign stable_o = stable_q;
endmodule

// File: rtl/move_input_conditioner.sv
// move_input_conditioner: debounced fire/switch front end with qualified fire strobe; MOVE_COUNT_EN adds move_count
module move_input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fire_btn_raw,
  input  logic [N_SEL_LINES-1:0] sw_raw,
  input  logic                   nrow_raw,
  output logic                   fire_pulse,
  output logic [N_SEL_LINES-1:0] row_sel,
  output logic [N_SEL_LINES-1:0] col_sel,
  output logic                   error,
  output logic                   reject_pulse
`ifdef MOVE_COUNT_EN
  ,
  output logic [MOVE_COUNT_W-1:0] move_count
`endif
);
  logic [N_SEL_LINES+1:0] raw, deb;
  logic [N_SEL_LINES-1:0] sw_s, row_sel_d, col_sel_d, row_sel_q, col_sel_q;
  logic [2:0] pop;
  logic fire_s, nrow_s, valid, rise;
  logic fire_pulse_d, fire_pulse_q, reject_pulse_d, reject_pulse_q, error_d, error_q;
  fire_state_e state_d, state_q;
  assign raw = {nrow_raw, fire_btn_raw, sw_raw};
  for (genvar g = 0; g < N_SEL_LINES + 2; g++) begin : g_deb
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_deb (
      .clk(clk),
      .reset(reset),
      .raw_i(raw[g]),
      .stable_o(deb[g])
    );
  end
  // Selection and fire decision share one register stage so they stay aligned
  always_comb begin
    sw_s = deb[N_SEL_LINES-1:0];
    fire_s = deb[N_SEL_LINES];
    nrow_s = deb[N_SEL_LINES+1];
    pop = popcount4(sw_s);
    valid = pop == 3'd1;
    error_d = pop >= 3'd2;
    row_sel_d = (valid && !nrow_s) ? sw_s : '0;
    col_sel_d = (valid && nrow_s) ? sw_s : '0;
    rise = (state_q == IDLE) && fire_s;
    fire_pulse_d = rise && valid;
    reject_pulse_d = rise && !valid;
    state_d = fire_s ? WAIT_RELEASE : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      fire_pulse_q <= 1'b0;
      reject_pulse_q <= 1'b0;
      error_q <= 1'b0;
      row_sel_q <= '0;
      col_sel_q <= '0;
    end else begin
      state_q <= state_d;
      fire_pulse_q <= fire_pulse_d;
      reject_pulse_q <= reject_pulse_d;
      error_q <= error_d;
      row_sel_q <= row_sel_d;
      col_sel_q <= col_sel_d;
    end
  assign fire_pulse = fire_pulse_q;
  assign reject_pulse = reject_pulse_q;
  assign error = error_q;
  assign row_sel = row_sel_q;
  assign col_sel = col_sel_q;
`ifdef MOVE_COUNT_EN
  logic [MOVE_COUNT_W-1:0] move_count_d, move_count_q;
  always_comb
    move_count_d = (fire_pulse_d && move_count_q != '1) ? move_count_q + 1'b1 : move_count_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) move_count_q <= '0;
    else move_count_q <= move_count_d;
  assign move_count = move_count_q;
`endif
endmodule

// File: tb/tb_move_input_conditioner.sv
// tb_move_input_conditioner: directed checks of debounce, selection and fire qualification
module tb_move_input_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fire_btn_raw = 1'b0;
  logic [3:0] sw_raw = '0;
  logic nrow_raw = 1'b0;
  logic fire_pulse, error, reject_pulse;
  logic [3:0] row_sel, col_sel;
`ifdef MOVE_COUNT_EN
  logic [7:0] move_count;
`endif
  int total = 0, passed = 0;
  int cyc = 0, fire_cnt = 0, rej_cnt = 0, both_cnt = 0, last_fire = 0, c0 = 0;
  logic [3:0] row_at_fire, col_at_fire;

  move_input_conditioner #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .fire_btn_raw(fire_btn_raw),
    .sw_raw(sw_raw),
    .nrow_raw(nrow_raw),
    .fire_pulse(fire_pulse),
    .row_sel(row_sel),
    .col_sel(col_sel),
    .error(error),
    .reject_pulse(reject_pulse)
`ifdef MOVE_COUNT_EN
    ,
    .move_count(move_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else passed++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (fire_pulse) begin
        fire_cnt++;
        last_fire = cyc;
        row_at_fire = row_sel;
        col_at_fire = col_sel;
      end
      if (reject_pulse) rej_cnt++;
      if (fire_pulse && reject_pulse) both_cnt++;
    end
  endtask

  task automatic clr();
    fire_cnt = 0;
    rej_cnt = 0;
    last_fire = 0;
    row_at_fire = 'x;
    col_at_fire = 'x;
  endtask

  initial begin
    tick(3);
    check("rst_fire", fire_pulse, 0);
    check("rst_reject", reject_pulse, 0);
    check("rst_row", row_sel, 0);
    check("rst_col", col_sel, 0);
    check("rst_error", error, 0);
    reset = 1'b0;
    sw_raw = 4'b0010;
    nrow_raw = 1'b0;
    tick(10);
    check("row_sel_0010", row_sel, 4'b0010);
    clr();
    fire_btn_raw = 1'b1;
    c0 = cyc;
    tick(20);
    check("t1_fire_cnt", fire_cnt, 1);
    check("t1_latency", last_fire - c0, 7);
    check("t1_row_at_fire", row_at_fire, 4'b0010);
    check("t1_col_at_fire", col_at_fire, 4'b0000);
    check("t1_reject_cnt", rej_cnt, 0);
    fire_btn_raw = 1'b0;
    tick(10);

    sw_raw = 4'b0110;
    tick(10);
    check("t2_error", error, 1);
    check("t2_row", row_sel, 0);
    check("t2_col", col_sel, 0);
    clr();
    fire_btn_raw = 1'b1;
    tick(15);
    fire_btn_raw = 1'b0;
    tick(10);
    check("t2_reject_cnt", rej_cnt, 1);
    check("t2_fire_cnt", fire_cnt, 0);

    sw_raw = 4'b1000;
    nrow_raw = 1'b1;
    tick(10);
    check("t3_error", error, 0);
    check("t3_col", col_sel, 4'b1000);
    check("t3_row", row_sel, 0);
    clr();
    for (int i = 0; i < 15; i++) begin
      fire_btn_raw = ~fire_btn_raw;
      tick(2);
    end
    fire_btn_raw = 1'b0;
    tick(6);
    check("t3_toggle_fire", fire_cnt, 0);
    check("t3_toggle_reject", rej_cnt, 0);
    fire_btn_raw = 1'b1;
    tick(20);
    check("t3_hold_fire", fire_cnt, 1);
    check("t3_col_at_fire", col_at_fire, 4'b1000);
    check("t3_row_at_fire", row_at_fire, 4'b0000);
    fire_btn_raw = 1'b0;
    tick(10);

    sw_raw = 4'b1100;
    tick(3);
    sw_raw = 4'b1000;
    tick(10);
    check("glitch_error", error, 0);
    check("glitch_col", col_sel, 4'b1000);

    clr();
    fire_btn_raw = 1'b1;
    tick(50);
    fire_btn_raw = 1'b0;
    tick(10);
    fire_btn_raw = 1'b1;
    tick(20);
    check("t4_two_presses", fire_cnt, 2);
    check("t4_reject", rej_cnt, 0);

    #1;
    reset = 1'b1;
    #1;
    check("t5_async_fire", fire_pulse, 0);
    check("t5_async_col", col_sel, 0);
    check("t5_async_row", row_sel, 0);
    check("t5_async_error", error, 0);
    tick(3);
    clr();
    reset = 1'b0;
    c0 = cyc;
    tick(15);
    check("t5_fire_cnt", fire_cnt, 1);
    check("t5_latency", last_fire - c0, 7);
    check("t5_reject", rej_cnt, 0);
    fire_btn_raw = 1'b0;
    tick(10);
`ifdef MOVE_COUNT_EN
    check("mc_after_reset", move_count, 1);
    for (int i = 0; i < 260; i++) begin
      fire_btn_raw = 1'b1;
      tick(10);
      fire_btn_raw = 1'b0;
      tick(10);
    end
    check("mc_saturate", move_count, 255);
`endif
    check("never_both", both_cnt, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
